// File: rtl/led_pattern_engine_if.sv
// Pin-side bundle for led_pattern_engine: switches and buttons in, LED/RGB
// pattern outputs out. The engine connects through the slave modport.
interface led_pattern_engine_if #(
   parameter int N_LEDS = 4,
   parameter int NB_SW  = 4,
   parameter int NB_BTN = 4
);
   logic [NB_SW-1:0]  i_sw;
   logic [NB_BTN-1:0] i_btn;
   logic [N_LEDS-1:0] o_led;
   logic [N_LEDS-1:0] o_led_r;
   logic [N_LEDS-1:0] o_led_g;
   logic [N_LEDS-1:0] o_led_b;

   modport master (
      output i_sw, i_btn,
      input  o_led, o_led_r, o_led_g, o_led_b
   );

   modport slave (
      input  i_sw, i_btn,
      output o_led, o_led_r, o_led_g, o_led_b
   );
endinterface

// File: rtl/led_pattern_engine.sv
// LED pattern engine: shift/flash/bounce/fill patterns at a switch-selected rate,
// routed to one RGB channel. Optional RGB dimming when LED_PATTERN_DIM_EN is defined.
module led_pattern_engine #(
   parameter int N_LEDS     = 4,
   parameter int NB_COUNT   = 32,
   parameter int NB_SW      = 4,
   parameter int NB_BTN     = 4,
   parameter int DEB_CYCLES = 16
`ifdef LED_PATTERN_DIM_EN
   ,
   parameter int DIM_DUTY   = 4
`endif
) (
   input  logic                 clock,
   input  logic                 i_reset,
   led_pattern_engine_if.slave  bus
);

   localparam int DEB_W      = $clog2(DEB_CYCLES + 1);
   localparam int SHIFT_BASE = NB_COUNT - 10;

   localparam logic [NB_COUNT-1:0] CNT_ZERO  = {NB_COUNT{1'b0}};
   localparam logic [NB_COUNT-1:0] CNT_ONE   = NB_COUNT'(1);
   localparam logic [N_LEDS-1:0]   LEDS_ZERO = {N_LEDS{1'b0}};
   localparam logic [N_LEDS-1:0]   LEDS_ONES = {N_LEDS{1'b1}};
   localparam logic [N_LEDS-1:0]   LEDS_ONE  = N_LEDS'(1);
   localparam logic [DEB_W-1:0]    DEB_ZERO  = {DEB_W{1'b0}};
   localparam logic [DEB_W-1:0]    DEB_STEP  = DEB_W'(1);
   localparam logic [DEB_W-1:0]    DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      MODE_SHIFT  = 2'd0,
      MODE_FLASH  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_FILL   = 2'd3
   } mode_e;

   logic [NB_BTN-1:0]   sync1_q, sync1_d;
   logic [NB_BTN-1:0]   sync2_q, sync2_d;
   logic [NB_BTN-1:0]   deb_q, deb_d;
   logic [NB_BTN-1:0]   deb_prev_q, deb_prev_d;
   logic [DEB_W-1:0]    deb_cnt_q [NB_BTN];
   logic [DEB_W-1:0]    deb_cnt_d [NB_BTN];
   logic [NB_BTN-1:0]   press_s;

   logic [NB_COUNT-1:0] counter_q, counter_d;
   logic [NB_COUNT-1:0] limit_s;
   logic                enable_s;
   logic                tick_s;

   mode_e               mode_q, mode_d;
   logic [N_LEDS-1:0]   pattern_q, pattern_d;
   logic [N_LEDS-1:0]   adv_pattern_s;
   logic                bounce_dir_q, bounce_dir_d;
   logic                adv_dir_s;
   logic [2:0]          colour_q, colour_d;

   logic [N_LEDS-1:0]   led_q, led_d;
   logic [N_LEDS-1:0]   led_r_q, led_r_d;
   logic [N_LEDS-1:0]   led_g_q, led_g_d;
   logic [N_LEDS-1:0]   led_b_q, led_b_d;
   logic                dim_off_s;

   // Button synchroniser and debounce: level follows sync only after DEB_CYCLES steady mismatches.
   always_comb begin
      sync1_d    = bus.i_btn;
      sync2_d    = sync1_q;
      deb_prev_d = deb_q;
      deb_d      = deb_q;
      for (int i = 0; i < NB_BTN; i++) begin
         deb_cnt_d[i] = DEB_ZERO;
         if (sync2_q[i] != deb_q[i]) begin
            if (deb_cnt_q[i] == DEB_LAST) begin
               deb_d[i]     = sync2_q[i];
               deb_cnt_d[i] = DEB_ZERO;
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + DEB_STEP;
            end
         end else begin
            deb_cnt_d[i] = DEB_ZERO;
         end
      end
      press_s = deb_q & ~deb_prev_q;
   end

   // Prescaler limit and tick; >= lets a lowered speed fire on the next cycle.
   always_comb begin
      enable_s = bus.i_sw[0];
      limit_s  = (CNT_ONE << (SHIFT_BASE + int'(bus.i_sw[2:1]))) - CNT_ONE;
      tick_s   = enable_s && (counter_q >= limit_s);
   end

   // Pattern advance for one tick in the current mode.
   always_comb begin
      adv_pattern_s = pattern_q;
      adv_dir_s     = bounce_dir_q;
      case (mode_q)
         MODE_SHIFT: begin
            if (bus.i_sw[3]) begin
               adv_pattern_s = {pattern_q[N_LEDS-2:0], pattern_q[N_LEDS-1]};
            end else begin
               adv_pattern_s = {pattern_q[0], pattern_q[N_LEDS-1:1]};
            end
         end
         MODE_FLASH: begin
            adv_pattern_s = ~pattern_q;
         end
         MODE_BOUNCE: begin
            // Reversal and the step back happen together so an end bit lasts one tick.
            if (bounce_dir_q) begin
               if (pattern_q[N_LEDS-1]) begin
                  adv_dir_s     = 1'b0;
                  adv_pattern_s = {1'b0, pattern_q[N_LEDS-1:1]};
               end else begin
                  adv_pattern_s = {pattern_q[N_LEDS-2:0], 1'b0};
               end
            end else begin
               if (pattern_q[0]) begin
                  adv_dir_s     = 1'b1;
                  adv_pattern_s = {pattern_q[N_LEDS-2:0], 1'b0};
               end else begin
                  adv_pattern_s = {1'b0, pattern_q[N_LEDS-1:1]};
               end
            end
         end
         MODE_FILL: begin
            if (&pattern_q) begin
               adv_pattern_s = LEDS_ZERO;
            end else begin
               adv_pattern_s = {pattern_q[N_LEDS-2:0], 1'b1};
            end
         end
         default: begin
            adv_pattern_s = LEDS_ONE;
         end
      endcase
   end

   // Mode FSM next state, counter, pattern and colour; mode press beats tick.
   always_comb begin
      mode_d       = mode_q;
      counter_d    = counter_q;
      pattern_d    = pattern_q;
      bounce_dir_d = bounce_dir_q;
      colour_d     = colour_q;
      if (enable_s) begin
         if (press_s[0]) begin
            counter_d = CNT_ZERO;
            case (mode_q)
               MODE_SHIFT: begin
                  mode_d    = MODE_FLASH;
                  pattern_d = LEDS_ONES;
               end
               MODE_FLASH: begin
                  mode_d       = MODE_BOUNCE;
                  pattern_d    = LEDS_ONE;
                  bounce_dir_d = bus.i_sw[3];
               end
               MODE_BOUNCE: begin
                  mode_d    = MODE_FILL;
                  pattern_d = LEDS_ZERO;
               end
               MODE_FILL: begin
                  mode_d    = MODE_SHIFT;
                  pattern_d = LEDS_ONE;
               end
               default: begin
                  mode_d    = MODE_SHIFT;
                  pattern_d = LEDS_ONE;
               end
            endcase
         end else if (tick_s) begin
            counter_d    = CNT_ZERO;
            pattern_d    = adv_pattern_s;
            bounce_dir_d = adv_dir_s;
         end else begin
            counter_d = counter_q + CNT_ONE;
         end

         if (press_s[1]) begin
            colour_d = 3'b001;
         end else if (press_s[2]) begin
            colour_d = 3'b010;
         end else if (press_s[3]) begin
            colour_d = 3'b100;
         end else begin
            colour_d = colour_q;
         end
      end else begin
         mode_d = mode_q;
      end
   end

`ifdef LED_PATTERN_DIM_EN
   logic [3:0] pwm_cnt_q, pwm_cnt_d;

   // Free-running PWM phase for RGB dimming.
   always_comb begin
      pwm_cnt_d = pwm_cnt_q + 4'd1;
      dim_off_s = ({1'b0, pwm_cnt_d} >= 5'(DIM_DUTY));
   end

   // PWM phase register.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         pwm_cnt_q <= 4'd0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
      end
   end
`else
   assign dim_off_s = 1'b0;
`endif

   // Output register inputs, built from next-state so outputs track state with no extra cycle.
   always_comb begin
      led_d       = LEDS_ZERO;
      led_d[1:0]  = mode_d;
      led_r_d     = LEDS_ZERO;
      led_g_d     = LEDS_ZERO;
      led_b_d     = LEDS_ZERO;
      if (!dim_off_s) begin
         led_r_d = colour_d[0] ? pattern_d : LEDS_ZERO;
         led_g_d = colour_d[1] ? pattern_d : LEDS_ZERO;
         led_b_d = colour_d[2] ? pattern_d : LEDS_ZERO;
      end else begin
         led_r_d = LEDS_ZERO;
      end
   end

   // Button front-end registers.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         sync1_q    <= {NB_BTN{1'b0}};
         sync2_q    <= {NB_BTN{1'b0}};
         deb_q      <= {NB_BTN{1'b0}};
         deb_prev_q <= {NB_BTN{1'b0}};
         for (int i = 0; i < NB_BTN; i++) begin
            deb_cnt_q[i] <= DEB_ZERO;
         end
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         deb_q      <= deb_d;
         deb_prev_q <= deb_prev_d;
         for (int i = 0; i < NB_BTN; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
         end
      end
   end

   // Engine state and output registers.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         counter_q    <= CNT_ZERO;
         mode_q       <= MODE_SHIFT;
         pattern_q    <= LEDS_ONE;
         bounce_dir_q <= 1'b0;
         colour_q     <= 3'b001;
         led_q        <= LEDS_ZERO;
         led_r_q      <= LEDS_ONE;
         led_g_q      <= LEDS_ZERO;
         led_b_q      <= LEDS_ZERO;
      end else begin
         counter_q    <= counter_d;
         mode_q       <= mode_d;
         pattern_q    <= pattern_d;
         bounce_dir_q <= bounce_dir_d;
         colour_q     <= colour_d;
         led_q        <= led_d;
         led_r_q      <= led_r_d;
         led_g_q      <= led_g_d;
         led_b_q      <= led_b_d;
      end
   end

   assign bus.o_led   = led_q;
   assign bus.o_led_r = led_r_q;
   assign bus.o_led_g = led_g_q;
   assign bus.o_led_b = led_b_q;

endmodule
